// File: rtl/shiftmul.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned.
// Magnitudes are multiplied unsigned over WIDTH cycles, then the sign is applied in FIX.
module shiftmul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_lo,
  output logic [WIDTH-1:0] p_hi
);

  // Handshake: trigger is accepted only on an edge where the unit is idle (busy = 0);
  // done then drops on that edge and rises, level-held, WIDTH+1 edges later with the result.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_p_lo;
  logic [WIDTH-1:0]   r_p_hi;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;

  // -0x80..0 wraps to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign w_a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_result   = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p_lo   <= '0;
      r_p_hi   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trigger) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // r_mcand is kept pre-shifted, so it always equals mcand << count.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_p_hi, r_p_lo} <= w_result;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p_lo = r_p_lo;
  assign p_hi = r_p_hi;

endmodule

// File: tb/tb_shiftmul.sv
// Randomized and directed bench for shiftmul with a plain-arithmetic product model
// and an expected-result queue.
module tb_shiftmul;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         trigger;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] p_lo;
  logic [W-1:0] p_hi;

  logic [2*W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  shiftmul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .p_lo(p_lo), .p_hi(p_hi)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact product from sign- or zero-extended operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
    ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = 1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drive one operation, scribble on the operands while busy, optionally pulse a
  // retrigger at cycle retrig_at, then check latency, busy span and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [2*W-1:0] expv, input int retrig_at);
    int n;
    int bc;
    logic [2*W-1:0] e;
    @(negedge clk);
    a = ta; b = tb_v; is_signed = ts; trigger = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    check("accept_done_low", {63'd0, done}, 64'd0);
    check("accept_busy", {63'd0, busy}, 64'd1);
    n = 0; bc = 0;
    for (int i = 0; i < W + 20; i++) begin
      @(negedge clk);
      if (n + 1 == retrig_at) begin
        a = 5; b = 5; is_signed = 1'b0; trigger = 1'b1;
      end else begin
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1)); trigger = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
      if (done) break;
    end
    trigger = 1'b0;
    e = exp_q.pop_front();
    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(n), 64'(W + 1));
      check("busy_cycles", 64'(bc), 64'(W));
      check("product", {p_hi, p_lo}, e);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_prod"}, {p_hi, p_lo}, 64'd0);
  endtask

  initial begin
    int e1, e2, nd;
    logic [2*W-1:0] p1, p2;
    logic [W-1:0] ra, rb;
    logic rs;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; trigger = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #2;
    check_zero("reset_async");
    #10;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_zero("reset_idle");

    // directed values with hand-derived products
    run_op(12345, 10, 1'b0, 64'd123450, 0);
    run_op(32'hFFFF_FFF9, 6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 0);
    run_op(32'hFFFF_FFF9, 6, 1'b0, 64'h0000_0005_FFFF_FFD6, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run_op(32'h0, 32'h8000_0000, 1'b1, 64'd0, 0);

    // retrigger while busy is ignored; a later trigger is taken normally
    run_op(3, 4, 1'b0, 64'd12, 10);
    run_op(5, 5, 1'b0, 64'd25, 0);

    // async reset mid-operation, between clock edges
    @(negedge clk);
    a = 9; b = 9; is_signed = 1'b0; trigger = 1'b1;
    @(posedge clk);
    @(negedge clk) trigger = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("midop_reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_zero("after_reset");
    run_op(2, 3, 1'b0, 64'd6, 0);

    // trigger held high: back-to-back operations
    @(negedge clk);
    a = 1; b = 1; is_signed = 1'b0; trigger = 1'b1;
    @(posedge clk);
    e1 = -1; e2 = -1; nd = 0; p1 = '0; p2 = '0;
    for (int e = 1; e <= 90; e++) begin
      @(negedge clk);
      a = 2; b = 2;
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (nd == 1) begin e1 = e; p1 = {p_hi, p_lo}; end
        else begin e2 = e; p2 = {p_hi, p_lo}; end
      end
      if (nd == 2) break;
    end
    @(negedge clk) trigger = 1'b0;
    check("held_done_count", 64'(nd), 64'd2);
    check("held_first_edge", 64'(e1), 64'(W + 1));
    check("held_first_prod", p1, 64'd1);
    check("held_spacing", 64'(e2 - e1), 64'(W + 2));
    check("held_second_prod", p2, 64'd4);
    @(posedge clk); #1;

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      ra = pick(); rb = pick(); rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shiftmul.md
Name: shiftmul

Overview:
- Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.
- Arithmetic counterpart to the iterative divmod unit, with the same trigger/done handshake.
- Serves the multiply bytecodes (imul low word; lmul-style full product) in the execution datapath.
- Supports signed (two's complement) and unsigned operands, selected per operation.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  start request; sampled only while idle.
- is_signed  input  1  1 = treat a and b as two's complement; 0 = unsigned. Sampled with trigger.
- a  input  WIDTH  multiplicand; sampled with trigger.
- b  input  WIDTH  multiplier; sampled with trigger.
- busy  output  1  high while an operation is in progress (CALC or FIX).
- done  output  1  result valid; level signal.
- p_lo  output  WIDTH  low half of the product.
- p_hi  output  WIDTH  high half of the product.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE; busy, done, p_lo, p_hi, internal registers and counter all 0.
  - Any in-flight operation is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, on a rising edge with trigger = 1:
  - Latch mcand = |a| and mplier = |b|. Magnitude is taken only if is_signed = 1 and the operand MSB = 1; otherwise the raw value is used.
  - Latch neg = is_signed & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and the counter; set done = 0, busy = 1; go to CALC.
  - If trigger = 0: hold state; done and the p_* outputs keep their previous values.
- CALC, one iteration per cycle for exactly WIDTH cycles:
  - If mplier[0] = 1, add mcand << count to the accumulator. The add is 2*WIDTH bits wide, no carry out.
  - Shift mplier right by 1; increment the counter.
  - After the WIDTH-th iteration, go to FIX.
- FIX, one cycle:
  - {p_hi, p_lo} = neg ? -acc : acc, as 2*WIDTH two's complement.
  - done = 1, busy = 0; go to IDLE.
- Latency: trigger accepted at edge k -> done = 1 and valid result after edge k+WIDTH+1 (33 edges for WIDTH = 32).
- done stays high, and p_lo/p_hi stay stable, until the next accepted trigger. On the accepting edge done drops to 0.
- trigger while busy = 1 is ignored; operands and result are unaffected and no request is queued.
- Operand changes after the accepting edge have no effect.
- Magnitude of the most-negative value (0x80..0) is 2^(WIDTH-1). This fits the unsigned WIDTH-bit mcand/mplier registers, so the result is exact.
- Any zero operand yields an all-zero product with no negative zero, because -0 = 0.
- trigger held high continuously: a new operation starts on every edge where the unit is IDLE, i.e. back-to-back operations with done high for one cycle each.
- Product overflow is impossible: the full 2*WIDTH result is always exact. Java imul semantics use p_lo only.

Test Plan:
- Unsigned 12345 x 10, trigger pulsed one cycle -> busy high for 33 cycles, then done = 1, p_lo = 123450, p_hi = 0.
- Signed -7 (0xFFFFFFF9) x 6 -> p_lo = 0xFFFFFFD6, p_hi = 0xFFFFFFFF. Same operands unsigned -> p_hi = 0x00000005, p_lo = 0xFFFFFFD6.
- Edge values:
  - Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> p_hi = 0xFFFFFFFE, p_lo = 0x00000001.
  - Signed 0x80000000 x 0x80000000 -> p_hi = 0x40000000, p_lo = 0.
  - Signed 0 x 0x80000000 -> both halves 0.
- Retrigger:
  - Start 3 x 4, pulse trigger again with 5 x 5 at cycle 10 -> final result 12 and done timing unchanged.
  - Then trigger 5 x 5 after done -> done drops on the accepting edge, later p_lo = 25.
- Async reset asserted at cycle 15 of an operation, between clock edges -> busy, done, p_lo, p_hi read 0 immediately. After release, a fresh 2 x 3 yields 6 with full 33-cycle latency.
- trigger held high, operands 1 x 1 then changed to 2 x 2 -> consecutive results 1 then 4, done pulses one cycle each, 34 cycles apart.
